// File: rtl/icache_fetch_pkg.sv
// -----------------------------------------------------------------------------
// icache_fetch_pkg
// Shared constants, types and helpers for the direct-mapped instruction cache.
//   - ICacheIndexBits / ICacheAddrBits : default geometry (128 lines x 32 bits,
//                                        18 physical address bits)
//   - ICacheTagBus                     : tag width derived from the geometry
//   - ICacheIoRegion                   : addr[17:16] value of the uncached IO region
//   - ic_state_e                       : fetch FSM encodings (ICIdle / ICFetch)
//   - ic_is_io()                       : true for addresses in the IO region
// -----------------------------------------------------------------------------
package icache_fetch_pkg;

  localparam int ICacheIndexBits = 7;
  localparam int ICacheAddrBits  = 18;
  localparam int ICacheTagBus    = ICacheAddrBits - ICacheIndexBits - 2;

  localparam logic [1:0] ICacheIoRegion = 2'b11;

  typedef enum logic {
    ICIdle  = 1'b0,
    ICFetch = 1'b1
  } ic_state_e;

  // The IO window is fixed at bits 17:16 regardless of cache geometry.
  function automatic logic ic_is_io(input logic [31:0] addr);
    return addr[17:16] == ICacheIoRegion;
  endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for the direct-mapped instruction cache.
//   clk_in      system clock
//   rst_in      synchronous active-high reset; clears every valid bit
//   rd_idx_i    combinational read index
//   rd_valid_o  valid bit of the indexed line
//   rd_tag_o    stored tag of the indexed line
//   rd_data_o   stored instruction word of the indexed line
//   we_i        synchronous write enable (caller already qualifies with ready)
//   wr_idx_i    write index
//   wr_tag_i    tag to store
//   wr_data_i   instruction word to store
// A read and a write to the same index in one cycle returns the old contents.
// -----------------------------------------------------------------------------
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = ICacheIndexBits,
  parameter int TAG_BITS   = ICacheTagBus
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [31:0]           wr_data_i
);

  localparam int Lines = 1 << INDEX_BITS;

  logic [Lines-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q [Lines];
  logic [31:0]         data_q[Lines];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent
  // races between always_ff blocks.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset. Only the valid bits
  // need clearing; resetting the payload would forbid RAM inference and
  // add a large reset fan-out for no functional gain.
  always_ff @(posedge clk_in) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_fetch.sv
// -----------------------------------------------------------------------------
// icache_fetch
// Direct-mapped, read-only instruction cache between IF and the memory
// controller's instruction-fetch port. Hits return in the request cycle; a
// miss issues one word fetch, fills the line (except in the IO region) and
// forwards the word in the completion cycle.
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   rdy_in        global ready; low freezes all state
//   pc_i          fetch address
//   pc_req_i      IF requests the instruction at pc_i this cycle
//   flush_i       branch redirect; kills the in-flight fetch result
//   inst_valid_o  inst_o / inst_pc_o valid this cycle
//   inst_o        instruction word
//   inst_pc_o     address of inst_o
//   mc_req_o      word-fetch request to mem_ctrl (level, held until done)
//   mc_addr_o     word-aligned fetch address
//   mc_done_i     one-cycle completion pulse, mc_data_i valid
//   mc_data_i     fetched word
// -----------------------------------------------------------------------------
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = ICacheIndexBits,
  parameter int ADDR_BITS  = ICacheAddrBits
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_i,
  input  logic        pc_req_i,
  input  logic        flush_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        mc_req_o,
  output logic [31:0] mc_addr_o,
  input  logic        mc_done_i,
  input  logic [31:0] mc_data_i
);

  localparam int TagBits = ADDR_BITS - INDEX_BITS - 2;

  ic_state_e   state_q, state_d;
  logic [31:0] miss_pc_q, miss_pc_d;
  logic        drop_q, drop_d;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [TagBits-1:0]    pc_tag;
  logic                  rd_valid;
  logic [TagBits-1:0]    rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  fill;

  assign pc_idx = pc_i[INDEX_BITS+1:2];
  assign pc_tag = pc_i[ADDR_BITS-1:INDEX_BITS+2];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TagBits)
  ) u_array (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill & rdy_in),
    .wr_idx_i   (miss_pc_q[INDEX_BITS+1:2]),
    .wr_tag_i   (miss_pc_q[ADDR_BITS-1:INDEX_BITS+2]),
    .wr_data_i  (mc_data_i)
  );

  assign hit = pc_req_i & rd_valid & (rd_tag == pc_tag);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ICIdle;
      miss_pc_q <= '0;
      drop_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      miss_pc_q <= miss_pc_d;
      drop_q    <= drop_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    drop_d       = drop_q;
    fill         = 1'b0;
    inst_valid_o = 1'b0;
    inst_o       = '0;
    inst_pc_o    = '0;

    unique case (state_q)
      ICIdle: begin
        if (!flush_i) begin
          if (hit) begin
            inst_valid_o = 1'b1;
            inst_o       = rd_data;
            inst_pc_o    = pc_i;
          end else if (pc_req_i) begin
            miss_pc_d = {pc_i[31:2], 2'b00};
            drop_d    = 1'b0;
            state_d   = ICFetch;
          end
        end
      end

      ICFetch: begin
        // The memory side cannot be aborted, so a redirect only marks the
        // returning word as wrong-path; it is still written into the line.
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (mc_done_i) begin
          fill = !ic_is_io(miss_pc_q);
          if (!drop_q && !flush_i && pc_req_i && (pc_i == miss_pc_q)) begin
            inst_valid_o = 1'b1;
            inst_o       = mc_data_i;
            inst_pc_o    = miss_pc_q;
          end
          drop_d  = 1'b0;
          state_d = ICIdle;
        end
      end

      default: state_d = ICIdle;
    endcase
  end

  assign mc_req_o  = (state_q == ICFetch);
  assign mc_addr_o = (state_q == ICFetch) ? miss_pc_q : '0;

endmodule

// File: tb/tb_icache_fetch.sv
// -----------------------------------------------------------------------------
// tb_icache_fetch
// Directed bench for icache_fetch. Inputs change 1 time unit after the rising
// edge; outputs are compared 2 units later, well away from either edge.
// -----------------------------------------------------------------------------
module tb_icache_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_i;
  logic        pc_req_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        mc_req_o;
  logic [31:0] mc_addr_o;
  logic        mc_done_i;
  logic [31:0] mc_data_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  icache_fetch dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .pc_i         (pc_i),
    .pc_req_i     (pc_req_i),
    .flush_i      (flush_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .mc_req_o     (mc_req_o),
    .mc_addr_o    (mc_addr_o),
    .mc_done_i    (mc_done_i),
    .mc_data_i    (mc_data_i)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Probe the cache combinationally and withdraw the request before the edge
  // so a miss never starts a fetch.
  task automatic probe(input string name, input logic [31:0] pc, input logic exp_hit,
                       input logic [31:0] exp_data);
    pc_i     = pc;
    pc_req_i = 1'b1;
    settle();
    check({name, "_valid"}, {31'b0, inst_valid_o}, {31'b0, exp_hit});
    if (exp_hit) begin
      check({name, "_inst"}, inst_o, exp_data);
      check({name, "_pc"}, inst_pc_o, pc);
    end
    check({name, "_noreq"}, {31'b0, mc_req_o}, 32'd0);
    pc_req_i = 1'b0;
    #1;
    next();
  endtask

  // Full miss: miss cycle, n waiting FETCH cycles, then the done cycle.
  task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] data,
                       input int n);
    pc_i     = pc;
    pc_req_i = 1'b1;
    settle();
    check({name, "_misscyc_valid"}, {31'b0, inst_valid_o}, 32'd0);
    check({name, "_misscyc_req"}, {31'b0, mc_req_o}, 32'd0);
    next();
    for (int i = 0; i < n; i++) begin
      settle();
      check({name, "_wait_req"}, {31'b0, mc_req_o}, 32'd1);
      check({name, "_wait_addr"}, mc_addr_o, pc);
      next();
    end
    mc_done_i = 1'b1;
    mc_data_i = data;
    settle();
    check({name, "_done_valid"}, {31'b0, inst_valid_o}, 32'd1);
    check({name, "_done_inst"}, inst_o, data);
    check({name, "_done_pc"}, inst_pc_o, pc);
    next();
    mc_done_i = 1'b0;
    mc_data_i = '0;
    pc_req_i  = 1'b0;
    settle();
    check({name, "_after_req"}, {31'b0, mc_req_o}, 32'd0);
    next();
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    pc_i      = '0;
    pc_req_i  = 1'b0;
    flush_i   = 1'b0;
    mc_done_i = 1'b0;
    mc_data_i = '0;
    next();
    next();
    rst_in = 1'b0;
    settle();
    check("rst_req", {31'b0, mc_req_o}, 32'd0);
    check("rst_addr", mc_addr_o, 32'd0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", inst_pc_o, 32'd0);
    next();

    // Cold miss and hit after fill.
    fetch("cold", 32'h0000_0000, 32'h0000_0013, 4);
    probe("hit0", 32'h0000_0000, 1'b1, 32'h0000_0013);

    // Conflict on index 1: 0x0004 and 0x0204 evict each other.
    fetch("fill4", 32'h0000_0004, 32'hAAAA_0004, 2);
    probe("hit4", 32'h0000_0004, 1'b1, 32'hAAAA_0004);
    fetch("fill204", 32'h0000_0204, 32'hBBBB_0204, 2);
    probe("hit204", 32'h0000_0204, 1'b1, 32'hBBBB_0204);
    probe("evict4", 32'h0000_0004, 1'b0, 32'h0);
    probe("keep0", 32'h0000_0000, 1'b1, 32'h0000_0013);

    // Flush during FETCH: result dropped at done, line still filled.
    pc_i     = 32'h0000_0100;
    pc_req_i = 1'b1;
    next();
    settle();
    check("fl_req1", {31'b0, mc_req_o}, 32'd1);
    next();
    flush_i = 1'b1;
    pc_i    = 32'h0000_0200;
    settle();
    check("fl_addr2", mc_addr_o, 32'h0000_0100);
    next();
    flush_i = 1'b0;
    settle();
    check("fl_req3", {31'b0, mc_req_o}, 32'd1);
    next();
    pc_i      = 32'h0000_0100;
    mc_done_i = 1'b1;
    mc_data_i = 32'hCCCC_0100;
    settle();
    check("fl_done_valid", {31'b0, inst_valid_o}, 32'd0);
    next();
    mc_done_i = 1'b0;
    pc_req_i  = 1'b0;
    settle();
    check("fl_idle_req", {31'b0, mc_req_o}, 32'd0);
    next();
    probe("fl_hit100", 32'h0000_0100, 1'b1, 32'hCCCC_0100);
    settle();
    check("fl_no_refetch", {31'b0, mc_req_o}, 32'd0);
    next();

    // rdy_in low for 3 FETCH cycles; a flush while frozen must be ignored.
    pc_i     = 32'h0000_0008;
    pc_req_i = 1'b1;
    next();
    settle();
    check("rdy_req", {31'b0, mc_req_o}, 32'd1);
    rdy_in   = 1'b0;
    pc_req_i = 1'b0;
    pc_i     = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      next();
      flush_i = (i == 1);
      settle();
      check("rdy_hold_req", {31'b0, mc_req_o}, 32'd1);
      check("rdy_hold_addr", mc_addr_o, 32'h0000_0008);
    end
    next();
    flush_i   = 1'b0;
    rdy_in    = 1'b1;
    pc_i      = 32'h0000_0008;
    pc_req_i  = 1'b1;
    mc_done_i = 1'b1;
    mc_data_i = 32'hDDDD_0008;
    settle();
    check("rdy_done_valid", {31'b0, inst_valid_o}, 32'd1);
    check("rdy_done_inst", inst_o, 32'hDDDD_0008);
    next();
    mc_done_i = 1'b0;
    pc_req_i  = 1'b0;
    settle();
    check("rdy_idle_req", {31'b0, mc_req_o}, 32'd0);
    next();
    probe("rdy_hit8", 32'h0000_0008, 1'b1, 32'hDDDD_0008);

    // IO region: forwarded but never cached; index 0 keeps its old line.
    fetch("io", 32'h0003_0000, 32'h0000_DEAD, 1);
    probe("io_miss", 32'h0003_0000, 1'b0, 32'h0);
    probe("io_keep0", 32'h0000_0000, 1'b1, 32'h0000_0013);

    // Reset mid-FETCH abandons the request and invalidates every line.
    pc_i     = 32'h0000_000C;
    pc_req_i = 1'b1;
    next();
    settle();
    check("mr_req", {31'b0, mc_req_o}, 32'd1);
    rst_in   = 1'b1;
    pc_req_i = 1'b0;
    next();
    rst_in = 1'b0;
    settle();
    check("mr_req_off", {31'b0, mc_req_o}, 32'd0);
    check("mr_addr_off", mc_addr_o, 32'd0);
    next();
    probe("mr_miss0", 32'h0000_0000, 1'b0, 32'h0);
    probe("mr_miss204", 32'h0000_0204, 1'b0, 32'h0);
    probe("mr_miss100", 32'h0000_0100, 1'b0, 32'h0);
    probe("mr_miss8", 32'h0000_0008, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
